// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_pkg
//  Description : Shared constants and seven-segment decode for the GPIO
//                board bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

    localparam int DEFAULT_NUM_SW          = 18;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int DEFAULT_REFRESH_CYCLES  = 50000;
    localparam int DEFAULT_HEX_DIGITS      = 8;

    typedef logic [6:0] seg_t;

    // All segments off (active-low).
    localparam seg_t SEG_BLANK = 7'h7F;

    // Hex nibble to active-low segments {g,f,e,d,c,b,a}.
    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_debounce
//  Description : Two-flop synchronizer followed by a shared-counter debouncer.
//                A new value is accepted only after it has been seen unchanged
//                on the synchronizer output for DEBOUNCE_CYCLES+1 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_NUM_SW,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_sw,
    output logic [WIDTH-1:0] o_stable,
    output logic             o_changed
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [WIDTH-1:0]   r_cand;
    logic [WIDTH-1:0]   r_stable;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_changed;

    // Bring the asynchronous switch pins into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
        end
    end

    // Any difference restarts the count; once the count saturates the
    // candidate is (re)loaded each cycle, flagging only real changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand    <= '0;
            r_cnt     <= '0;
            r_stable  <= '0;
            r_changed <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_cnt  <= '0;
            end else if (r_cnt < c_CNT_LAST) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end else begin
                r_stable  <= r_cand;
                r_changed <= (r_cand != r_stable);
            end
        end
    end

    assign o_stable  = r_stable;
    assign o_changed = r_changed;

endmodule
`default_nettype wire

// File: rtl/gpio_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_io_bridge
//  Description : Board-side GPIO bridge. Feeds the CPU debounced switches and
//                scans the CPU output word onto an 8-digit multiplexed,
//                active-low seven-segment display.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_io_bridge
    import gpio_pkg::*;
#(
    parameter int NUM_SW          = DEFAULT_NUM_SW,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REFRESH_CYCLES  = DEFAULT_REFRESH_CYCLES,
    parameter int HEX_DIGITS      = DEFAULT_HEX_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SW-1:0]     sw,
    input  logic [31:0]           gpio_out,
    output logic [31:0]           gpio_in,
    output logic                  gpio_in_changed,
    output logic [6:0]            seg_n,
    output logic [HEX_DIGITS-1:0] dig_sel_n
);

    localparam int                  c_IDX_W     = $clog2(HEX_DIGITS);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(HEX_DIGITS - 1);
    localparam int                  c_RCNT_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [c_RCNT_W-1:0] c_RCNT_LAST = c_RCNT_W'(REFRESH_CYCLES - 1);

    logic [NUM_SW-1:0]       w_stable;
    logic [c_RCNT_W-1:0]     r_rcnt;
    logic [c_IDX_W-1:0]      r_idx;
    logic [4*HEX_DIGITS-1:0] r_disp;
    logic [6:0]              r_seg_n;
    logic [HEX_DIGITS-1:0]   r_dig_sel_n;

    gpio_debounce #(
        .WIDTH           (NUM_SW),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .i_sw      (sw),
        .o_stable  (w_stable),
        .o_changed (gpio_in_changed)
    );

    // Zero-extend the switch word; a full-width switch bank needs no padding.
    generate
        if (NUM_SW < 32) begin : g_pad
            assign gpio_in = {{(32 - NUM_SW){1'b0}}, w_stable};
        end else begin : g_full
            assign gpio_in = w_stable;
        end
    endgenerate

    // Advance the digit every REFRESH_CYCLES; latch a new word only at frame
    // wrap so a frame never mixes two values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rcnt <= '0;
            r_idx  <= '0;
            r_disp <= '0;
        end else if (r_rcnt == c_RCNT_LAST) begin
            r_rcnt <= '0;
            r_idx  <= r_idx + c_IDX_W'(1);
            if (r_idx == c_IDX_LAST) begin
                r_disp <= gpio_out;
            end
        end else begin
            r_rcnt <= r_rcnt + c_RCNT_W'(1);
        end
    end

    // Register segments and digit enable together so they switch in lockstep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_n     <= SEG_BLANK;
            r_dig_sel_n <= '1;
        end else begin
            r_seg_n     <= hex_to_seg(r_disp[{r_idx, 2'b00} +: 4]);
            r_dig_sel_n <= ~(HEX_DIGITS'(1) << r_idx);
        end
    end

    assign seg_n     = r_seg_n;
    assign dig_sel_n = r_dig_sel_n;

endmodule
`default_nettype wire
